cla_pipe: RTL
=============

CLA_PIPE -- requirements
Module: cla_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/sum width in bits; WIDTH SHALL be a multiple of STAGES.
REQ-002 Parameter STAGES, default 4, pipeline depth (1..8); chunk width CW = WIDTH/STAGES.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 sum  output  WIDTH  result bits.
REQ-013 cout  output  1  carry out of bit WIDTH-1.
REQ-014 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-015 Transfer on input SHALL occur iff in_valid && in_ready; on output iff out_valid && out_ready.
REQ-016 Stage k (0..STAGES-1) SHALL compute chunk k (bits k*CW..k*CW+CW-1) with per-bit g=a&b, p=a|b and CW-bit lookahead carries, using the carry registered by stage k-1 (cin for k=0).
REQ-017 Each stage register SHALL hold: valid bit, sum chunks 0..k, carry out of chunk k, unconsumed a/b chunks k+1..STAGES-1, carry into MSB (last stage only).
REQ-018 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no backpressure; throughput one result per cycle.
REQ-019 Stage k SHALL load when it is empty or its contents advance this cycle; the last stage advances on output transfer.
REQ-020 in_ready SHALL be high iff stage 0 is empty or stage 0 advances this cycle (bubbles collapse; ready chain is combinational).
REQ-021 A stalled stage SHALL hold all contents unchanged; no beat SHALL be dropped or duplicated.
REQ-022 Results SHALL leave in acceptance order.
REQ-023 sum, cout, ovf SHALL be driven directly from last-stage registers; their value is don't-care while out_valid is low.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; {cout,sum} = a + b + cin exactly.
REQ-025 Simultaneous input and output transfer with the pipeline full SHALL be legal and sustain full throughput.
REQ-026 in_valid deasserted SHALL create a bubble that propagates as an invalid stage.

Reset
REQ-027 While rst is high, all stage valid bits SHALL clear at the next clock edge; out_valid SHALL be 0 the cycle after.
REQ-028 Reset mid-operation SHALL discard all in-flight beats; data registers need no reset.
REQ-029 in_ready SHALL be 0 while rst is high and 1 in the first cycle after rst falls.

Configuration
REQ-030 Macro CLA_PIPE_SUB_EN defined: input port sub (1 bit, sampled with the beat, carried through the pipeline) SHALL exist; effective operands are b ^ {WIDTH{sub}} and cin ^ sub, so sub=1, cin=0 yields a - b.
REQ-031 CLA_PIPE_SUB_EN undefined: port sub SHALL be absent and the block SHALL add only.

Verification (WIDTH=32, STAGES=4)
REQ-032 a=0xFFFFFFFF, b=0, cin=1, out_ready=1 -> after 4 cycles sum=0, cout=1, ovf=0.
REQ-033 a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, cout=0, ovf=1; carry crosses all chunk boundaries.
REQ-034 8 back-to-back beats, a=i, b=i<<8, with out_ready held 0 for cycles 3..6 -> all 8 results appear in order, none lost; in_ready low only while full and stalled.
REQ-035 Pipeline full, assert rst one cycle -> out_valid=0 next cycle, no stale result later emerges.
REQ-036 With CLA_PIPE_SUB_EN: sub=1, a=5, b=7, cin=0 -> sum=0xFFFFFFFE, cout=0; mixed add/sub beats keep per-beat mode.
REQ-037 Random a, b, cin, in_valid, out_ready for 10^5 cycles, also WIDTH=64/STAGES=8 and WIDTH=8/STAGES=1 -> every result matches the reference sum, order preserved.

Source files
------------

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder: STAGES chunk stages of WIDTH/STAGES bits, valid/ready handshake on both sides.
// Optional CLA_PIPE_SUB_EN adds a per-beat 'sub' input that turns the beat into a - b.
module cla_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  // Handshake: a beat moves on when valid && ready on the same cycle; a stage
  // loads when it is empty or its current beat moves on this cycle.
  logic [STAGES-1:0] vld_d, vld_q, vld_src, adv, load;
  logic              nxt_load;
  logic              sub_in;

`ifdef CLA_PIPE_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // Carries c[1..CW] expanded as sums of generate terms with propagate chains.
  function automatic logic [CW:0] cla_carries(input logic [CW-1:0] g,
                                              input logic [CW-1:0] p,
                                              input logic          c0);
    logic [CW:0] c;
    logic        term;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < CW; i++) begin
      term = c0;
      for (int m = 0; m <= i; m++) term = term & p[m];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  always_comb begin
    adv      = '0;
    load     = '0;
    nxt_load = out_ready;
    vld_src  = (vld_q << 1) | STAGES'(in_valid);
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k]   = vld_q[k] & nxt_load;
      load[k]  = ~vld_q[k] | adv[k];
      nxt_load = load[k];
    end
    vld_d = vld_q;
    for (int k = 0; k < STAGES; k++) begin
      if (load[k]) vld_d[k] = vld_src[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  assign in_ready  = load[0] & ~rst;
  assign out_valid = vld_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int REM = (STAGES - 1 - k) * CW;

    logic [CW-1:0]       a_ck, b_ck, s_ck;
    logic                c_in;
    logic [CW:0]         cy;
    logic [(k+1)*CW-1:0] sum_d, sum_q;
    logic                c_d, c_q;

    if (k == 0) begin : g_src
      assign a_ck  = a[CW-1:0];
      assign b_ck  = b[CW-1:0] ^ {CW{sub_in}};
      assign c_in  = cin ^ sub_in;
      assign sum_d = s_ck;
    end else begin : g_src
      assign a_ck  = stg[k-1].g_fwd.a_q[CW-1:0];
      assign b_ck  = stg[k-1].g_fwd.b_q[CW-1:0] ^ {CW{stg[k-1].g_fwd.sub_q}};
      assign c_in  = stg[k-1].c_q;
      assign sum_d = {s_ck, stg[k-1].sum_q};
    end

    always_comb begin
      cy   = cla_carries(a_ck & b_ck, a_ck | b_ck, c_in);
      s_ck = a_ck ^ b_ck ^ cy[CW-1:0];
      c_d  = cy[CW];
    end

    always_ff @(posedge clk) begin
      if (load[k]) begin
        sum_q <= sum_d;
        c_q   <= c_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      // Operand chunks not yet consumed, packed down so the next chunk sits at bit 0.
      logic [REM-1:0] a_d, a_q, b_d, b_q;
      logic           sub_d, sub_q;

      if (k == 0) begin : g_in
        assign a_d   = a[WIDTH-1:CW];
        assign b_d   = b[WIDTH-1:CW];
        assign sub_d = sub_in;
      end else begin : g_in
        assign a_d   = stg[k-1].g_fwd.a_q[REM+CW-1:CW];
        assign b_d   = stg[k-1].g_fwd.b_q[REM+CW-1:CW];
        assign sub_d = stg[k-1].g_fwd.sub_q;
      end

      always_ff @(posedge clk) begin
        if (load[k]) begin
          a_q   <= a_d;
          b_q   <= b_d;
          sub_q <= sub_d;
        end
      end
    end else begin : g_last
      logic cmsb_d, cmsb_q;
      assign cmsb_d = cy[CW-1];

      always_ff @(posedge clk) begin
        if (load[k]) cmsb_q <= cmsb_d;
      end
    end
  end

  assign sum  = stg[STAGES-1].sum_q;
  assign cout = stg[STAGES-1].c_q;
  assign ovf  = stg[STAGES-1].c_q ^ stg[STAGES-1].g_last.cmsb_q;

endmodule
